branch_resolve_unit: RTL and testbench

- EX-stage consumer of gshare fetch predictions, and producer of its training inputs.
- Fetch pushes each predicted instruction's {pc, predTaken, predTarget} into an in-order prediction queue.
- EX pops the queue head, resolves the actual outcome and drives the predictor update port (exBranch/exTaken/exPc/exTarget).
- On mispredict it raises a registered redirect and flush, then drains the queue.

---
 rtl/bru_pkg.sv | 18 +
 rtl/pred_fifo.sv | 61 ++++++
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: prediction queue entry, FSM state
// and instruction size.
package bru_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        predTaken;
    logic [31:0] predTarget;
  } pred_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/pred_fifo.sv
// Circular FIFO of pred_entry_t with push, pop and clear. Clear drops every entry
// and takes priority over a push or pop in the same cycle.
module pred_fifo
  import bru_pkg::*;
#(
  parameter  int unsigned QDEPTH = 4,
  localparam int unsigned PTR_W  = $clog2(QDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  pred_entry_t       wrData,
  input  logic              pop,
  input  logic              clear,
  output pred_entry_t       rdData,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
);

  pred_entry_t      mem [QDEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  always_comb begin
    full   = (count == (PTR_W + 1)'(QDEPTH));
    empty  = (count == '0);
    // A push at full is only taken when a pop frees the head slot in the same cycle.
    doPush = push & (~full | pop);
    doPop  = pop & ~empty;
    rdData = mem[rdPtr];
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= wrPtr;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (doPop && !doPush) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: pops fetch predictions, trains the predictor and
// redirects fetch on mispredict. Optional perf counters: BRU_PERF_COUNTERS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter  int unsigned QDEPTH = 4,
  localparam int unsigned PTR_W  = $clog2(QDEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fqValid,
  output logic        fqReady,
  input  logic [31:0] fqPc,
  input  logic        fqPredTaken,
  input  logic [31:0] fqPredTarget,
  input  logic        exValid,
  input  logic        exIsBranch,
  input  logic        exIsJump,
  input  logic        exCondTrue,
  input  logic [31:0] exPc,
  input  logic [31:0] exCalcTarget,
  output logic        bpUpdate,
  output logic        bpTaken,
  output logic [31:0] bpPc,
  output logic [31:0] bpTarget,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic        flush,
`ifdef BRU_PERF_COUNTERS_EN
  output logic [31:0] perfBranches,
  output logic [31:0] perfMispredicts,
`endif
  output logic        seqErr
);

  state_t         state;
  pred_entry_t    head;
  pred_entry_t    wrEntry;
  logic [PTR_W:0] count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           clear;
  logic           isCtl;
  logic           actTaken;
  logic [31:0]    seqNext;
  logic [31:0]    actNext;
  logic [31:0]    predNext;
  logic           mispredict;
  logic           seqBad;

  always_comb begin
    clear    = (state == FLUSH);
    fqReady  = ~full & (state == RUN);
    push     = fqValid & fqReady;
    pop      = exValid & (state == RUN);
    wrEntry  = '{pc: fqPc, predTaken: fqPredTaken, predTarget: fqPredTarget};
    isCtl    = exIsBranch | exIsJump;
    actTaken = exIsJump | (exIsBranch & exCondTrue);
    seqNext  = exPc + 32'(INSTR_BYTES);
    actNext  = actTaken ? exCalcTarget : seqNext;
    // An empty queue carries no prediction, so resolve as predicted fall-through.
    predNext = (!empty && head.predTaken) ? head.predTarget : seqNext;
    mispredict = (actNext != predNext);
    seqBad   = (count == '0) | (head.pc != exPc);
  end

  pred_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wrData (wrEntry),
    .pop    (pop),
    .clear  (clear),
    .rdData (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      bpUpdate      <= 1'b0;
      bpTaken       <= 1'b0;
      bpPc          <= '0;
      bpTarget      <= '0;
      redirectValid <= 1'b0;
      redirectPc    <= '0;
      flush         <= 1'b0;
      seqErr        <= 1'b0;
    end else begin
      bpUpdate <= pop & isCtl;
      if (pop && isCtl) begin
        bpTaken  <= actTaken;
        bpPc     <= exPc;
        bpTarget <= exCalcTarget;
      end
      if (pop && seqBad) seqErr <= 1'b1;

      case (state)
        RUN: begin
          if (pop && mispredict) begin
            redirectValid <= 1'b1;
            flush         <= 1'b1;
            redirectPc    <= actNext;
            state         <= FLUSH;
          end else begin
            redirectValid <= 1'b0;
            flush         <= 1'b0;
          end
        end
        default: begin
          redirectValid <= 1'b0;
          flush         <= 1'b0;
          state         <= RUN;
        end
      endcase
    end
  end

`ifdef BRU_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perfBranches    <= '0;
      perfMispredicts <= '0;
    end else begin
      if (pop && isCtl && perfBranches != '1) begin
        perfBranches <= perfBranches + 32'd1;
      end
      if (pop && mispredict && perfMispredicts != '1) begin
        perfMispredicts <= perfMispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a behavioural queue model predicts
// each cycle's registered outputs, which are compared one cycle later.
module tb_branch_resolve_unit;
  import bru_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fqValid = 1'b0;
  logic        fqReady;
  logic [31:0] fqPc = '0;
  logic        fqPredTaken = 1'b0;
  logic [31:0] fqPredTarget = '0;
  logic        exValid = 1'b0;
  logic        exIsBranch = 1'b0;
  logic        exIsJump = 1'b0;
  logic        exCondTrue = 1'b0;
  logic [31:0] exPc = '0;
  logic [31:0] exCalcTarget = '0;
  logic        bpUpdate;
  logic        bpTaken;
  logic [31:0] bpPc;
  logic [31:0] bpTarget;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        flush;
  logic        seqErr;
`ifdef BRU_PERF_COUNTERS_EN
  logic [31:0] perfBranches;
  logic [31:0] perfMispredicts;
`endif

  branch_resolve_unit #(.QDEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .fqValid       (fqValid),
    .fqReady       (fqReady),
    .fqPc          (fqPc),
    .fqPredTaken   (fqPredTaken),
    .fqPredTarget  (fqPredTarget),
    .exValid       (exValid),
    .exIsBranch    (exIsBranch),
    .exIsJump      (exIsJump),
    .exCondTrue    (exCondTrue),
    .exPc          (exPc),
    .exCalcTarget  (exCalcTarget),
    .bpUpdate      (bpUpdate),
    .bpTaken       (bpTaken),
    .bpPc          (bpPc),
    .bpTarget      (bpTarget),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .flush         (flush),
`ifdef BRU_PERF_COUNTERS_EN
    .perfBranches    (perfBranches),
    .perfMispredicts (perfMispredicts),
`endif
    .seqErr        (seqErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bpu;
    logic        bpt;
    logic [31:0] bpp;
    logic [31:0] bptg;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic        se;
  } exp_t;

  exp_t        sb[$];
  pred_entry_t mq[$];
  exp_t        m;
  logic        mflush;
  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mflush = 1'b0;
    m = '{bpu: 1'b0, bpt: 1'b0, bpp: '0, bptg: '0, rv: 1'b0, rpc: '0, fl: 1'b0, se: 1'b0};
  endtask

  // One clock with the given fetch/EX stimulus; expectations go through the scoreboard.
  task automatic step(input logic fv, input logic [31:0] fpc, input logic fpt,
                      input logic [31:0] ftg, input logic ev, input logic ib,
                      input logic ij, input logic ct, input logic [31:0] epc,
                      input logic [31:0] etg);
    logic        ready;
    logic        hv;
    logic        at;
    logic [31:0] an;
    logic [31:0] pn;
    pred_entry_t h;
    exp_t        e;
    fqValid = fv; fqPc = fpc; fqPredTaken = fpt; fqPredTarget = ftg;
    exValid = ev; exIsBranch = ib; exIsJump = ij; exCondTrue = ct;
    exPc = epc; exCalcTarget = etg;
    #1;
    ready = (mq.size() < 4) && !mflush;
    check("fqReady", fqReady, ready);
    if (mflush) begin
      mq.delete();
      m.rv = 1'b0; m.fl = 1'b0; m.bpu = 1'b0;
      mflush = 1'b0;
    end else begin
      m.bpu = 1'b0;
      if (ev) begin
        hv = (mq.size() > 0);
        h  = '0;
        if (hv) h = mq.pop_front();
        if (!hv || h.pc != epc) m.se = 1'b1;
        at = ij | (ib & ct);
        an = at ? etg : epc + 32'd4;
        pn = (hv && h.predTaken) ? h.predTarget : epc + 32'd4;
        if (ib | ij) begin
          m.bpu = 1'b1; m.bpt = at; m.bpp = epc; m.bptg = etg;
        end
        if (an != pn) begin
          m.rv = 1'b1; m.fl = 1'b1; m.rpc = an; mflush = 1'b1;
        end else begin
          m.rv = 1'b0; m.fl = 1'b0;
        end
      end else begin
        m.rv = 1'b0; m.fl = 1'b0;
      end
      if (fv && ready) mq.push_back('{pc: fpc, predTaken: fpt, predTarget: ftg});
    end
    sb.push_back(m);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("bpUpdate", bpUpdate, e.bpu);
    check("bpTaken", bpTaken, e.bpt);
    check("bpPc", bpPc, e.bpp);
    check("bpTarget", bpTarget, e.bptg);
    check("redirectValid", redirectValid, e.rv);
    check("redirectPc", redirectPc, e.rpc);
    check("flush", flush, e.fl);
    check("seqErr", seqErr, e.se);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fqValid = 1'b1; fqPc = $urandom; fqPredTaken = 1'($urandom);
      fqPredTarget = $urandom; exValid = 1'b1; exIsBranch = 1'($urandom);
      exIsJump = 1'($urandom); exCondTrue = 1'($urandom);
      exPc = $urandom; exCalcTarget = $urandom;
      @(posedge clk); #1;
    end
    model_clear();
    check("rst_bpUpdate", bpUpdate, 0);
    check("rst_bpTaken", bpTaken, 0);
    check("rst_bpPc", bpPc, 0);
    check("rst_bpTarget", bpTarget, 0);
    check("rst_redirectValid", redirectValid, 0);
    check("rst_redirectPc", redirectPc, 0);
    check("rst_flush", flush, 0);
    check("rst_seqErr", seqErr, 0);
    check("rst_fqReady", fqReady, 1);
    rst = 1'b1;
    fqValid = 1'b0; exValid = 1'b0;
  endtask

  initial begin
    logic [31:0] npc;
    pred_entry_t h;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Correct taken prediction
    step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 1, 32'h100, 32'h200);
    check("t2_bpPc", bpPc, 32'h100);
    check("t2_bpTarget", bpTarget, 32'h200);

    // Predicted not-taken but taken; a push in the mispredict cycle is discarded
    step(1, 32'h104, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h999, 1, 32'h777, 1, 1, 0, 1, 32'h104, 32'h40);
    check("t3_redirectPc", redirectPc, 32'h40);
    idle();
    idle();

    // Non-branch aliasing a taken prediction
    step(1, 32'h108, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 32'h108, 32'h0);
    check("t4_redirectPc", redirectPc, 32'h10C);
    idle();

    // Correct jump, correct not-taken, then predicted-taken resolving not-taken
    step(1, 32'h200, 1, 32'h250, 0, 0, 0, 0, 0, 0);
    step(1, 32'h204, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0, 32'h200, 32'h250);
    step(1, 32'h300, 1, 32'h400, 1, 1, 0, 0, 32'h204, 32'h280);
    step(0, 0, 0, 0, 1, 1, 0, 0, 32'h300, 32'h400);
    idle();

    // Fill to full, then stream push+pop across pointer wrap
    npc = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      step(1, npc, 1'(i), npc + 32'h80, 0, 0, 0, 0, 0, 0);
      npc += 32'd4;
    end
    for (int i = 0; i < 10; i++) begin
      h = mq[0];
      if (mq.size() < 4) begin
        step(1, npc, 1'(npc[2]), npc + 32'h80, 1, 1, 0, h.predTaken, h.pc, h.predTarget);
        npc += 32'd4;
      end else begin
        step(1, npc, 1'(npc[2]), npc + 32'h80, 1, 1, 0, h.predTaken, h.pc, h.predTarget);
      end
    end
    while (mq.size() > 0) begin
      h = mq[0];
      step(0, 0, 0, 0, 1, 1, 0, h.predTaken, h.pc, h.predTarget);
    end

    // Empty pop sets a sticky seqErr; mid-operation reset clears it
    step(0, 0, 0, 0, 1, 0, 0, 0, 32'h500, 32'h0);
    for (int i = 0; i < 3; i++) idle();
    step(1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
